load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits directly upstream of the word-addressed data memory in the MIPS datapath.
- Takes load/store requests (byte, halfword, word; signed or unsigned loads) from the MEM stage.
- Converts byte addresses to word indices and performs sub-word stores as read-modify-write sequences.
- Returns aligned, extended load data, stalling the pipeline while busy.

Parameters:
- MEM_WORDS, 10000, depth of the attached data memory in 32-bit words.
- ADDR_W, 32, width of the byte address from the pipeline.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present this cycle
- req_ready  out  1  unit can accept a request (high only in IDLE)
- MemRead  in  1  request is a load
- MemWrite  in  1  request is a store
- size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- sign_ext  in  1  loads: 1 sign-extend, 0 zero-extend
- Address  in  ADDR_W  byte address
- StoreData  in  32  store data; sub-word data is in the LSBs
- LoadData  out  32  extended load result, held until next done
- done  out  1  one-cycle pulse on completion
- err  out  1  valid with done; request rejected, no memory access
- stall  out  1  high from accept until done inclusive; low otherwise
- dm_addr  out  32  word index to memory, equal to Address[31:2] zero-extended
- dm_read  out  1  memory read strobe
- dm_write  out  1  memory write strobe
- dm_wdata  out  32  memory write data
- dm_rdata  in  32  memory read data, combinational from dm_addr/dm_read

Behaviour:
- Reset values:
  - state=IDLE
  - req_ready=1, done=0, err=0, stall=0
  - LoadData=0, dm_addr=0, dm_read=0, dm_write=0, dm_wdata=0
  - captured request registers cleared.
- Accept: req_valid & req_ready & (MemRead|MemWrite) latches Address, size, sign_ext, StoreData and the op. Inputs are don't-care afterwards.
- Idle: req_valid with neither MemRead nor MemWrite is ignored.
- Little-endian lanes: byte n of the word is bits [8n+7:8n]; halfword at offset 2 is bits [31:16].
- Error checks, run in the cycle after accept; a failing request goes to DONE with err=1 and no dm_read/dm_write pulse:
  - size==11
  - halfword with Address[0]=1
  - word with Address[1:0]!=0
  - MemRead and MemWrite both high
- States:
  - IDLE: waits for accept. A load goes to LD. A word store goes to ST. A sub-word store goes to RMW_RD. A request that fails the error checks goes to DONE with err=1.
  - LD: dm_read=1; capture dm_rdata, then extract/extend lane into LoadData. Goes to DONE.
  - ST: dm_write=1, dm_wdata=StoreData. Goes to DONE.
  - RMW_RD: dm_read=1; capture the old word. Goes to RMW_WR.
  - RMW_WR: dm_write=1, dm_wdata = old word with the target lane replaced by StoreData LSBs. Goes to DONE.
  - DONE: done=1; err is valid this cycle. Goes to IDLE, where req_ready rises.
- Latency, accept edge to done pulse:
  - loads and word stores: 2 cycles
  - sub-word stores: 3 cycles
  - errors: 1 cycle
- Back-to-back: a new request can be accepted the cycle after done.
- dm_read and dm_write are never high in the same cycle. Both are low outside LD/ST/RMW_*.
- LoadData changes only when a load completes without error; stores and errors leave it unchanged.
- Reset mid-operation: immediately returns to IDLE with reset values. A write strobe in progress is withdrawn.

Optional Feature:
- Macro LSU_BOUNDS_CHECK_EN.
- Defined: any request with Address[31:2] >= MEM_WORDS completes as an error (done, err=1, no memory strobe, 1-cycle latency).
- Undefined: no range check; the word index is driven to memory unchanged.

Decomposition:
- Shared package lsu_pkg holds:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10
  - state encoding constants
- One sub-module, lsu_lane_align (combinational):
  - load: word + offset + size + sign_ext -> extended result
  - store: old word + new data + offset + size -> merged word
- The FSM stays in load_store_unit.

Test Plan:
- Word store/load: store 0xDEADBEEF to 0x10 -> dm_write with dm_addr=4 in ST; load word from 0x10 -> done 2 cycles after accept, LoadData=0xDEADBEEF.
- Signed byte load: memory[4]=0x80FF7F01.
  - lb from 0x12 -> LoadData=0xFFFFFFFF
  - lbu from 0x13 -> 0x00000080
  - lb from 0x10 -> 0x00000001
- Sub-word store: memory[4]=0x11223344; sb 0xAA to 0x11 -> RMW_RD then RMW_WR with dm_wdata=0x1122AA44, done 3 cycles after accept; sh 0xBEEF to 0x12 -> 0xBEEFAA44.
- Misaligned: lh from 0x13 -> done with err=1 one cycle after accept, no dm_read, LoadData unchanged.
- Reset in RMW_WR: assert reset -> dm_write drops asynchronously, req_ready=1, memory word keeps its old value.
- With LSU_BOUNDS_CHECK_EN: lw from byte 40000 (index 10000) -> err=1, no strobe; without the macro, dm_addr=10000 and dm_read pulses.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// the captured request attributes.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LD     = 3'd1;
    localparam logic [2:0] S_ST     = 3'd2;
    localparam logic [2:0] S_RMW_RD = 3'd3;
    localparam logic [2:0] S_RMW_WR = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    typedef struct packed {
        logic [1:0] size;
        logic       sign_ext;
    } req_attr_t;

    function automatic logic size_or_align_bad(input logic [1:0] sz, input logic [1:0] offset);
        case (sz)
            SZ_HALF: return offset[0];
            SZ_WORD: return offset != 2'b00;
            SZ_ILL:  return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane handling: extracts/extends a load lane from a word and
// merges store data into the old word for sub-word stores.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] rd_word_i,
    input  logic [31:0] old_word_i,
    input  logic [31:0] new_data_i,
    input  logic [1:0]  offset_i,
    input  logic [1:0]  size_i,
    input  logic        sign_ext_i,
    output logic [31:0] ld_data_o,
    output logic [31:0] st_word_o
);

    logic [7:0]  lane8;
    logic [15:0] lane16;

    always_comb begin
        lane8     = rd_word_i[{offset_i, 3'b000} +: 8];
        lane16    = offset_i[1] ? rd_word_i[31:16] : rd_word_i[15:0];
        ld_data_o = rd_word_i;
        case (size_i)
            SZ_BYTE: ld_data_o = {{24{sign_ext_i & lane8[7]}}, lane8};
            SZ_HALF: ld_data_o = {{16{sign_ext_i & lane16[15]}}, lane16};
            default: ld_data_o = rd_word_i;
        endcase
    end

    always_comb begin
        st_word_o = old_word_i;
        case (size_i)
            SZ_BYTE: st_word_o[{offset_i, 3'b000} +: 8]  = new_data_i[7:0];
            SZ_HALF: st_word_o[{offset_i[1], 4'b0000} +: 16] = new_data_i[15:0];
            default: st_word_o = new_data_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the MEM stage and a word-addressed data memory.
// Define LSU_BOUNDS_CHECK_EN to reject word indices >= MEM_WORDS as errors.
//
// state  | meaning
// IDLE   | waiting for a request, req_ready high
// LD     | reading the word for a load
// ST     | writing a full word
// RMW_RD | reading the old word for a sub-word store
// RMW_WR | writing the merged word back
// DONE   | one-cycle completion pulse, err valid
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = 10000,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [ADDR_W-1:0] Address,
    input  logic [31:0]       StoreData,
    output logic [31:0]       LoadData,
    output logic              done,
    output logic              err,
    output logic              stall,
    output logic [31:0]       dm_addr,
    output logic              dm_read,
    output logic              dm_write,
    output logic [31:0]       dm_wdata,
    input  logic [31:0]       dm_rdata
);

    localparam logic [31:0] MEM_WORDS_L = 32'(MEM_WORDS);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    req_attr_t         attr_q, attr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       old_q, old_d;
    logic [31:0]       ldata_q, ldata_d;
    logic              err_q, err_d;

    logic        accept;
    logic        req_err;
    logic        out_of_range;
    logic [31:0] req_idx;
    logic [31:0] ld_ext;
    logic [31:0] st_merged;

    assign req_idx = 32'(Address[ADDR_W-1:2]);

`ifdef LSU_BOUNDS_CHECK_EN
    assign out_of_range = (req_idx >= MEM_WORDS_L);
`else
    logic unused_range_cmp;
    assign unused_range_cmp = (req_idx >= MEM_WORDS_L);
    assign out_of_range     = 1'b0;
`endif

    // Checks are resolved from the live request so errors complete one cycle after accept.
    assign accept  = req_valid && (state_q == S_IDLE) && (MemRead || MemWrite);
    assign req_err = (MemRead && MemWrite) || size_or_align_bad(size, Address[1:0]) || out_of_range;

    lsu_lane_align u_lane_align (
        .rd_word_i  (dm_rdata),
        .old_word_i (old_q),
        .new_data_i (wdata_q),
        .offset_i   (addr_q[1:0]),
        .size_i     (attr_q.size),
        .sign_ext_i (attr_q.sign_ext),
        .ld_data_o  (ld_ext),
        .st_word_o  (st_merged)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        attr_d  = attr_q;
        wdata_d = wdata_q;
        old_d   = old_q;
        ldata_d = ldata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    addr_d          = Address;
                    attr_d.size     = size;
                    attr_d.sign_ext = sign_ext;
                    wdata_d         = StoreData;
                    err_d           = req_err;
                    if (req_err)             state_d = S_DONE;
                    else if (MemRead)        state_d = S_LD;
                    else if (size == SZ_WORD) state_d = S_ST;
                    else                     state_d = S_RMW_RD;
                end
            end
            S_LD: begin
                ldata_d = ld_ext;
                state_d = S_DONE;
            end
            S_ST:     state_d = S_DONE;
            S_RMW_RD: begin
                old_d   = dm_rdata;
                state_d = S_RMW_WR;
            end
            S_RMW_WR: state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            attr_q  <= '0;
            wdata_q <= '0;
            old_q   <= '0;
            ldata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            attr_q  <= attr_d;
            wdata_q <= wdata_d;
            old_q   <= old_d;
            ldata_q <= ldata_d;
            err_q   <= err_d;
        end
    end

    // Strobes decode straight from state so an async reset withdraws them at once.
    assign req_ready = (state_q == S_IDLE);
    assign stall     = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign err       = done && err_q;
    assign LoadData  = ldata_q;
    assign dm_addr   = 32'(addr_q[ADDR_W-1:2]);
    assign dm_read   = (state_q == S_LD) || (state_q == S_RMW_RD);
    assign dm_write  = (state_q == S_ST) || (state_q == S_RMW_WR);

    always_comb begin
        dm_wdata = '0;
        if (state_q == S_ST)          dm_wdata = wdata_q;
        else if (state_q == S_RMW_WR) dm_wdata = st_merged;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus random
// traffic checked against a byte-level reference memory model.
`timescale 1ns/1ps
module tb_load_store_unit;

    localparam int MEM_WORDS = 10000;
    localparam int TB_WORDS  = 16384;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        sign_ext = 1'b0;
    logic [31:0] Address = '0;
    logic [31:0] StoreData = '0;
    logic [31:0] LoadData;
    logic        done, err, stall;
    logic [31:0] dm_addr;
    logic        dm_read, dm_write;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;

    int checks = 0;
    int errors = 0;

    load_store_unit #(.MEM_WORDS(MEM_WORDS), .ADDR_W(32)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .MemRead(MemRead), .MemWrite(MemWrite), .size(size), .sign_ext(sign_ext),
        .Address(Address), .StoreData(StoreData), .LoadData(LoadData),
        .done(done), .err(err), .stall(stall), .dm_addr(dm_addr),
        .dm_read(dm_read), .dm_write(dm_write), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
    );

    always #5 clk = ~clk;

    // Environment memory: written by the DUT or by preload, unwritten words read a fixed pattern.
    logic [31:0] mem [TB_WORDS];
    bit          written [TB_WORDS];
    logic        pre_we = 1'b0;
    logic [13:0] pre_idx = '0;
    logic [31:0] pre_data = '0;

    function automatic logic [31:0] init_val(input int i);
        return (32'(i) * 32'h9E3779B1) ^ 32'h0BADF00D;
    endfunction

    function automatic logic [31:0] env_word(input int i);
        return written[i] ? mem[i] : init_val(i);
    endfunction

    assign dm_rdata = env_word(int'(dm_addr[13:0]));

    always @(posedge clk) begin
        if (dm_write) begin
            mem[dm_addr[13:0]]     <= dm_wdata;
            written[dm_addr[13:0]] <= 1'b1;
        end else if (pre_we) begin
            mem[pre_idx]     <= pre_data;
            written[pre_idx] <= 1'b1;
        end
    end

    // Reference model: memory as bytes, loads assembled and extended arithmetically.
    logic [31:0] ref_mem [TB_WORDS];
    logic [31:0] ld_exp = '0;

    function automatic logic [7:0] ref_byte(input logic [31:0] a);
        logic [31:0] w;
        w = ref_mem[a[15:2]];
        return 8'(w >> (8 * int'(a[1:0])));
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input int nbytes, input logic sx);
        longint v;
        v = 0;
        for (int i = 0; i < nbytes; i++) v += longint'(ref_byte(a + 32'(i))) << (8 * i);
        if (sx && nbytes < 4 && v >= (longint'(1) << (8 * nbytes - 1))) v -= longint'(1) << (8 * nbytes);
        return 32'(v);
    endfunction

    task automatic ref_store(input logic [31:0] a, input int nbytes, input logic [31:0] d);
        for (int i = 0; i < nbytes; i++) begin
            logic [31:0] ba, w, b;
            int lane;
            ba   = a + 32'(i);
            lane = int'(ba[1:0]);
            w    = ref_mem[ba[15:2]];
            b    = (d >> (8 * i)) & 32'hFF;
            w    = (w & ~(32'hFF << (8 * lane))) | (b << (8 * lane));
            ref_mem[ba[15:2]] = w;
        end
    endtask

    function automatic logic ref_err(input logic ld, input logic st, input logic [1:0] sz, input logic [31:0] a);
        int nbytes;
        if (ld && st) return 1'b1;
        if (sz == 2'b11) return 1'b1;
        nbytes = 1 << sz;
        if ((a % nbytes) != 0) return 1'b1;
`ifdef LSU_BOUNDS_CHECK_EN
        if ((a >> 2) >= MEM_WORDS) return 1'b1;
`endif
        return 1'b0;
    endfunction

    typedef struct {
        int          lat;
        int          wait_c;
        int          rd_cnt;
        int          wr_cnt;
        logic [31:0] rd_addr;
        logic [31:0] wr_addr;
        logic [31:0] wr_data;
        logic        err;
        logic [31:0] ld_data;
        int          stall_bad;
        int          order_bad;
    } res_t;

    task automatic preload(input int idx, input logic [31:0] v);
        pre_we   = 1'b1;
        pre_idx  = idx[13:0];
        pre_data = v;
        @(posedge clk);
        #1 pre_we = 1'b0;
        ref_mem[idx] = v;
        @(negedge clk);
    endtask

    // Drives one request, then observes the transaction until done (bounded).
    task automatic do_req(input logic ld, input logic st, input logic [1:0] sz, input logic sx,
                          input logic [31:0] a, input logic [31:0] d, output res_t r);
        bit seen_done;
        r.lat = -1; r.wait_c = 0; r.rd_cnt = 0; r.wr_cnt = 0;
        r.rd_addr = '0; r.wr_addr = '0; r.wr_data = '0; r.err = 1'b0; r.ld_data = '0;
        r.stall_bad = 0; r.order_bad = 0;
        while (!req_ready && r.wait_c < 20) begin
            @(negedge clk);
            r.wait_c++;
        end
        MemRead = ld; MemWrite = st; size = sz; sign_ext = sx; Address = a; StoreData = d;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        MemRead = 1'($urandom); MemWrite = 1'($urandom); size = 2'($urandom);
        sign_ext = 1'($urandom); Address = $urandom; StoreData = $urandom;
        seen_done = 1'b0;
        for (int c = 1; c <= 10 && !seen_done; c++) begin
            @(negedge clk);
            if (!stall) r.stall_bad++;
            if (dm_read && dm_write) r.order_bad++;
            if (dm_read) begin
                r.rd_cnt++;
                r.rd_addr = dm_addr;
                if (r.wr_cnt != 0) r.order_bad++;
            end
            if (dm_write) begin
                r.wr_cnt++;
                r.wr_addr = dm_addr;
                r.wr_data = dm_wdata;
            end
            if (done) begin
                r.lat = c;
                r.err = err;
                r.ld_data = LoadData;
                seen_done = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #3;
        checks++;
        if ({req_ready, done, err, stall, dm_read, dm_write} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 100000", {req_ready, done, err, stall, dm_read, dm_write});
        end
        checks++;
        if (LoadData !== 32'h0) begin errors++; $display("FAIL reset_loaddata: got %h expected 0", LoadData); end
        checks++;
        if (dm_addr !== 32'h0) begin errors++; $display("FAIL reset_dm_addr: got %h expected 0", dm_addr); end
        checks++;
        if (dm_wdata !== 32'h0) begin errors++; $display("FAIL reset_dm_wdata: got %h expected 0", dm_wdata); end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_idle_ignore();
        req_valid = 1'b1; MemRead = 1'b0; MemWrite = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({req_ready, stall, dm_read, dm_write, done} !== 5'b10000) begin
                errors++;
                $display("FAIL idle_ignore: got %b expected 10000", {req_ready, stall, dm_read, dm_write, done});
            end
        end
        req_valid = 1'b0;
    endtask

    task automatic test_word_store_load();
        res_t r;
        do_req(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, r);
        ref_store(32'h10, 4, 32'hDEADBEEF);
        checks++;
        if (r.lat !== 2 || r.err !== 1'b0) begin errors++; $display("FAIL sw_latency: got lat %0d err %b expected 2/0", r.lat, r.err); end
        checks++;
        if (r.wr_cnt !== 1 || r.rd_cnt !== 0 || r.wr_addr !== 32'd4 || r.wr_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL sw_strobe: got wr %0d rd %0d addr %h data %h expected 1 0 4 deadbeef", r.wr_cnt, r.rd_cnt, r.wr_addr, r.wr_data);
        end
        do_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, r);
        ld_exp = ref_load(32'h10, 4, 1'b0);
        checks++;
        if (r.lat !== 2 || r.rd_cnt !== 1 || r.rd_addr !== 32'd4) begin
            errors++;
            $display("FAIL lw_strobe: got lat %0d rd %0d addr %h expected 2 1 4", r.lat, r.rd_cnt, r.rd_addr);
        end
        checks++;
        if (r.ld_data !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data: got %h expected deadbeef", r.ld_data); end
    endtask

    task automatic test_signed_loads();
        res_t r;
        logic [31:0] addrs [5];
        logic [1:0]  szs [5];
        logic        sxs [5];
        logic [31:0] exps [5];
        addrs = '{32'h12, 32'h13, 32'h10, 32'h12, 32'h10};
        szs   = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01};
        sxs   = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        exps  = '{32'hFFFFFFFF, 32'h00000080, 32'h00000001, 32'hFFFF80FF, 32'h00007F01};
        preload(4, 32'h80FF7F01);
        for (int i = 0; i < 5; i++) begin
            do_req(1'b1, 1'b0, szs[i], sxs[i], addrs[i], $urandom, r);
            ld_exp = exps[i];
            checks++;
            if (r.lat !== 2 || r.err !== 1'b0 || r.ld_data !== exps[i]) begin
                errors++;
                $display("FAIL subword_load_%0d: got lat %0d err %b data %h expected 2 0 %h", i, r.lat, r.err, r.ld_data, exps[i]);
            end
        end
    endtask

    task automatic test_subword_store();
        res_t r;
        preload(4, 32'h11223344);
        do_req(1'b0, 1'b1, 2'b00, 1'b0, 32'h11, 32'h000000AA, r);
        ref_store(32'h11, 1, 32'hAA);
        checks++;
        if (r.lat !== 3 || r.rd_cnt !== 1 || r.wr_cnt !== 1 || r.order_bad !== 0) begin
            errors++;
            $display("FAIL sb_sequence: got lat %0d rd %0d wr %0d order %0d expected 3 1 1 0", r.lat, r.rd_cnt, r.wr_cnt, r.order_bad);
        end
        checks++;
        if (r.wr_data !== 32'h1122AA44) begin errors++; $display("FAIL sb_merge: got %h expected 1122aa44", r.wr_data); end
        do_req(1'b0, 1'b1, 2'b01, 1'b0, 32'h12, 32'h1234BEEF, r);
        ref_store(32'h12, 2, 32'h1234BEEF);
        checks++;
        if (r.lat !== 3 || r.wr_data !== 32'hBEEFAA44) begin
            errors++;
            $display("FAIL sh_merge: got lat %0d data %h expected 3 beefaa44", r.lat, r.wr_data);
        end
    endtask

    task automatic test_errors();
        res_t r;
        logic        lds [4];
        logic        sts [4];
        logic [1:0]  szs [4];
        logic [31:0] adr [4];
        lds = '{1'b1, 1'b0, 1'b1, 1'b1};
        sts = '{1'b0, 1'b1, 1'b0, 1'b1};
        szs = '{2'b01, 2'b10, 2'b11, 2'b10};
        adr = '{32'h13, 32'h12, 32'h10, 32'h10};
        for (int i = 0; i < 4; i++) begin
            do_req(lds[i], sts[i], szs[i], 1'b1, adr[i], $urandom, r);
            checks++;
            if (r.lat !== 1 || r.err !== 1'b1 || r.rd_cnt !== 0 || r.wr_cnt !== 0) begin
                errors++;
                $display("FAIL err_case_%0d: got lat %0d err %b rd %0d wr %0d expected 1 1 0 0", i, r.lat, r.err, r.rd_cnt, r.wr_cnt);
            end
            checks++;
            if (r.ld_data !== ld_exp) begin errors++; $display("FAIL err_loaddata_%0d: got %h expected %h", i, r.ld_data, ld_exp); end
        end
    endtask

    task automatic test_back_to_back();
        res_t r;
        do_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, r);
        ld_exp = ref_load(32'h20, 4, 1'b0);
        checks++;
        if (req_ready !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready_in_done: got ready %b done %b expected 0 1", req_ready, done);
        end
        do_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h24, 32'h0, r);
        ld_exp = ref_load(32'h24, 4, 1'b0);
        checks++;
        if (r.wait_c !== 1 || r.lat !== 2 || r.ld_data !== ld_exp) begin
            errors++;
            $display("FAIL b2b_second: got wait %0d lat %0d data %h expected 1 2 %h", r.wait_c, r.lat, r.ld_data, ld_exp);
        end
    endtask

    task automatic test_reset_mid_rmw();
        res_t r;
        preload(4, 32'h11223344);
        MemRead = 1'b0; MemWrite = 1'b1; size = 2'b00; sign_ext = 1'b0; Address = 32'h11; StoreData = 32'h55;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (dm_write !== 1'b1) begin errors++; $display("FAIL rmw_wr_reached: got dm_write %b expected 1", dm_write); end
        #1 reset = 1'b1;
        #1;
        ld_exp = 32'h0;
        checks++;
        if ({dm_write, dm_read, req_ready, stall, done} !== 5'b00100) begin
            errors++;
            $display("FAIL rst_mid_ctrl: got %b expected 00100", {dm_write, dm_read, req_ready, stall, done});
        end
        checks++;
        if (LoadData !== ld_exp) begin errors++; $display("FAIL rst_mid_loaddata: got %h expected %h", LoadData, ld_exp); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        do_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, r);
        ld_exp = ref_load(32'h10, 4, 1'b0);
        checks++;
        if (r.ld_data !== 32'h11223344) begin errors++; $display("FAIL rst_mid_mem_kept: got %h expected 11223344", r.ld_data); end
    endtask

    task automatic test_bounds();
        res_t r;
        logic e;
        e = ref_err(1'b1, 1'b0, 2'b10, 32'd40000);
        do_req(1'b1, 1'b0, 2'b10, 1'b0, 32'd40000, 32'h0, r);
        if (!e) ld_exp = ref_load(32'd40000, 4, 1'b0);
        checks++;
        if (r.err !== e || r.lat !== (e ? 1 : 2) || r.rd_cnt !== (e ? 0 : 1)) begin
            errors++;
            $display("FAIL bounds_ctrl: got err %b lat %0d rd %0d expected %b %0d %0d", r.err, r.lat, r.rd_cnt, e, e ? 1 : 2, e ? 0 : 1);
        end
        checks++;
        if ((!e && r.rd_addr !== 32'd10000) || r.ld_data !== ld_exp) begin
            errors++;
            $display("FAIL bounds_data: got addr %0d data %h expected 10000 %h", r.rd_addr, r.ld_data, ld_exp);
        end
    endtask

    task automatic test_random();
        res_t r;
        for (int n = 0; n < 250; n++) begin
            int op, nb, exp_lat, exp_rd, exp_wr;
            logic ld, st, sx, e;
            logic [1:0] sz;
            logic [31:0] a, d;
            op = $urandom_range(0, 9);
            ld = (op <= 5);
            st = (op == 0) || (op >= 6);
            sz = 2'($urandom_range(0, 3));
            sx = 1'($urandom);
            a  = 32'($urandom_range(0, 255));
            d  = $urandom;
            e  = ref_err(ld, st, sz, a);
            nb = 1 << sz;
            exp_lat = e ? 1 : (ld ? 2 : (sz == 2'b10 ? 2 : 3));
            exp_rd  = e ? 0 : ((ld || sz != 2'b10) ? 1 : 0);
            exp_wr  = (e || ld) ? 0 : 1;
            do_req(ld, st, sz, sx, a, d, r);
            if (!e && ld) ld_exp = ref_load(a, nb, sx);
            if (!e && st) ref_store(a, nb, d);
            checks++;
            if (r.lat !== exp_lat || r.err !== e || r.rd_cnt !== exp_rd || r.wr_cnt !== exp_wr) begin
                errors++;
                $display("FAIL rand_%0d_ctrl: got lat %0d err %b rd %0d wr %0d expected %0d %b %0d %0d",
                         n, r.lat, r.err, r.rd_cnt, r.wr_cnt, exp_lat, e, exp_rd, exp_wr);
            end
            checks++;
            if (r.ld_data !== ld_exp) begin errors++; $display("FAIL rand_%0d_loaddata: got %h expected %h", n, r.ld_data, ld_exp); end
            checks++;
            if (r.stall_bad !== 0 || r.order_bad !== 0) begin
                errors++;
                $display("FAIL rand_%0d_stall_order: got stall_bad %0d order_bad %0d expected 0 0", n, r.stall_bad, r.order_bad);
            end
            if (exp_wr == 1) begin
                checks++;
                if (r.wr_addr !== (a >> 2) || r.wr_data !== ref_mem[a[15:2]]) begin
                    errors++;
                    $display("FAIL rand_%0d_wdata: got addr %h data %h expected %h %h", n, r.wr_addr, r.wr_data, a >> 2, ref_mem[a[15:2]]);
                end
            end
        end
    endtask

    task automatic test_mem_image();
        @(negedge clk);
        for (int i = 0; i < 64; i++) begin
            checks++;
            if (env_word(i) !== ref_mem[i]) begin
                errors++;
                $display("FAIL mem_word_%0d: got %h expected %h", i, env_word(i), ref_mem[i]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < TB_WORDS; i++) ref_mem[i] = init_val(i);
        test_reset();
        test_idle_ignore();
        test_word_store_load();
        test_signed_loads();
        test_subword_store();
        test_errors();
        test_back_to_back();
        test_reset_mid_rmw();
        test_bounds();
        test_random();
        test_mem_image();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
